// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver. Deserialises uart_rxd (LSB first) and
// presents each received word with a one-cycle uart_rx_valid pulse.
// A low line held through the stop bit with all-zero data is reported as a
// one-cycle uart_rx_break pulse. Frames with a bad stop bit and non-zero data
// are dropped silently.
// Optional feature: define UART_RX_PARITY_EN to expect an even-parity bit
// after the payload. A parity mismatch pulses uart_rx_perr instead of
// uart_rx_valid. When the macro is undefined, uart_rx_perr is tied to 0.
module uart_rx #(
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned BIT_RATE     = 115200,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_break,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_perr
);

  localparam int unsigned BIT_P          = 1_000_000_000 / BIT_RATE;
  localparam int unsigned CLK_P          = 1_000_000_000 / CLK_HZ;
  localparam int unsigned CYCLES_PER_BIT = BIT_P / CLK_P;
  localparam int unsigned HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int unsigned CNT_W          = 1 + $clog2(CYCLES_PER_BIT);
  localparam int unsigned BCNT_W         = 4;

  localparam logic [CNT_W-1:0]  BIT_CNT   = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_CNT  = CNT_W'(HALF_BIT);
  localparam logic [BCNT_W-1:0] DATA_LAST = BCNT_W'(PAYLOAD_BITS - 1);
  localparam logic [BCNT_W-1:0] STOP_LAST = BCNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    RECV,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              sync_q;
  logic                    rxs;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BCNT_W-1:0]       bits_q, bits_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic                    serr_q, serr_d;
  logic                    hold_q, hold_d;
  logic                    valid_q, valid_d;
  logic                    brk_q, brk_d;
  logic                    stop_bad;
`ifdef UART_RX_PARITY_EN
  logic                    pbad_q, pbad_d;
  logic                    perr_q, perr_d;
`endif

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], uart_rxd};
  end

  assign rxs = sync_q[1];

  // State, counters, shift register and output pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      serr_q  <= 1'b0;
      hold_q  <= 1'b0;
      valid_q <= 1'b0;
      brk_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_q  <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      serr_q  <= serr_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      brk_q   <= brk_d;
`ifdef UART_RX_PARITY_EN
      pbad_q  <= pbad_d;
      perr_q  <= perr_d;
`endif
    end
  end

  // Next-state logic: mid-bit sampling, frame checks and output pulses.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    bits_d   = bits_q;
    shift_d  = shift_q;
    data_d   = data_q;
    serr_d   = serr_q;
    // Break hold releases once the line has been seen high.
    hold_d   = hold_q & ~rxs;
    valid_d  = 1'b0;
    brk_d    = 1'b0;
    stop_bad = serr_q | ~rxs;
`ifdef UART_RX_PARITY_EN
    pbad_d   = pbad_q;
    perr_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        bits_d = '0;
        serr_d = 1'b0;
        if (uart_rx_en && !rxs && !hold_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          state_d = rxs ? IDLE : RECV;
        end
      end
      RECV: begin
        if (cnt_q == BIT_CNT) begin
          cnt_d                   = '0;
          shift_d                 = shift_q >> 1;
          shift_d[PAYLOAD_BITS-1] = rxs;
          bits_d                  = bits_q + BCNT_W'(1);
          if (bits_q == DATA_LAST) begin
            bits_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == BIT_CNT) begin
          cnt_d   = '0;
          pbad_d  = rxs ^ (^shift_q);
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == BIT_CNT) begin
          cnt_d  = '0;
          bits_d = bits_q + BCNT_W'(1);
          serr_d = stop_bad;
          // Leave at mid-stop so a back-to-back start edge is not missed.
          if (bits_q == STOP_LAST) begin
            state_d = IDLE;
            if (stop_bad) begin
              if (shift_q == '0) begin
                brk_d  = 1'b1;
                hold_d = 1'b1;
              end
`ifdef UART_RX_PARITY_EN
            end else if (pbad_q) begin
              perr_d = 1'b1;
`endif
            end else begin
              valid_d = 1'b1;
              data_d  = shift_q;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Disabling the receiver discards any partial frame without a pulse.
    if (!uart_rx_en) begin
      state_d = IDLE;
      cnt_d   = '0;
      bits_d  = '0;
      serr_d  = 1'b0;
      data_d  = data_q;
      hold_d  = hold_q & ~rxs;
      valid_d = 1'b0;
      brk_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d  = 1'b0;
`endif
    end
  end

  assign uart_rx_data  = data_q;
  assign uart_rx_valid = valid_q;
  assign uart_rx_break = brk_q;
`ifdef UART_RX_PARITY_EN
  assign uart_rx_perr  = perr_q;
`else
  assign uart_rx_perr  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 434 cycles/bit.
// Stimulus pushes the expected event for each frame, and a negedge monitor
// pops and compares expected events against the DUT output pulses.
module tb_uart_rx;

  localparam int CPB = 434;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       uart_rx_en = 1'b1;
  logic       uart_rx_break;
  logic       uart_rx_valid;
  logic       uart_rx_perr;
  logic [7:0] uart_rx_data;

  uart_rx #(
    .PAYLOAD_BITS(8),
    .CLK_HZ(50_000_000),
    .BIT_RATE(115200),
    .STOP_BITS(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .uart_rxd(uart_rxd),
    .uart_rx_en(uart_rx_en),
    .uart_rx_break(uart_rx_break),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_data(uart_rx_data),
    .uart_rx_perr(uart_rx_perr)
  );

  always #5 clk = ~clk;

  typedef enum int { EV_VALID = 0, EV_BREAK = 1, EV_PERR = 2 } ev_kind_t;
  typedef struct { ev_kind_t kind; logic [7:0] data; } ev_t;

  ev_t         exp_q[$];
  ev_t         mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  int unsigned last_valid_cyc = 0;
  logic [7:0]  model_data = 8'h00;
  logic [7:0]  prev_data = 8'h00;
  int          act_kind;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc > 200000) begin
      $display("FAIL watchdog: got %0d cycles, expected under 200000", cyc);
      $fatal(1, "watchdog expired");
    end
  end

  // Monitor: every output pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (!reset) begin
      if (uart_rx_valid || uart_rx_break || uart_rx_perr) begin
        check("pulse_exclusive", 32'(uart_rx_valid) + 32'(uart_rx_break) + 32'(uart_rx_perr), 1);
        act_kind = uart_rx_valid ? EV_VALID : (uart_rx_break ? EV_BREAK : EV_PERR);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse: got kind %0d, expected no pulse", act_kind);
        end else begin
          mon_e = exp_q.pop_front();
          check("event_kind", act_kind, int'(mon_e.kind));
          if (mon_e.kind == EV_VALID) check("rx_data", uart_rx_data, mon_e.data);
        end
        if (uart_rx_valid) last_valid_cyc = cyc;
      end
      if (uart_rx_data !== prev_data) check("data_changes_only_with_valid", uart_rx_valid, 1);
    end
    prev_data = uart_rx_data;
  end

  task automatic drive_bit(input logic b, input int n);
    uart_rxd = b;
    repeat (n) @(negedge clk);
  endtask

  // Expected outcome from the frame's content alone: bad stop means break
  // (all-zero data) or silent drop; otherwise parity error or a valid word.
  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par_flip);
    ev_t e;
    e.data = d;
    if (!stop_ok) begin
      if (d == 8'h00) begin
        e.kind = EV_BREAK;
        exp_q.push_back(e);
      end
    end else if (par_flip) begin
      e.kind = EV_PERR;
      exp_q.push_back(e);
    end else begin
      e.kind = EV_VALID;
      exp_q.push_back(e);
      model_data = d;
    end
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip, CPB);
`endif
    drive_bit(stop_ok, CPB);
    uart_rxd = 1'b1;
    check("event_by_stop_end", exp_q.size(), 0);
  endtask

  initial begin
    int unsigned c0;
    logic [7:0]  d;
    int          k;

    // Reset state
    repeat (5) @(negedge clk);
    check("reset_valid", uart_rx_valid, 0);
    check("reset_break", uart_rx_break, 0);
    check("reset_perr", uart_rx_perr, 0);
    check("reset_data", uart_rx_data, 0);
    reset = 1'b0;
    drive_bit(1'b1, 20);

    // 0xA5 with latency check from the start edge
    c0 = cyc;
    send_frame(8'hA5, 1'b1, 1'b0);
    check("a5_latency_ok",
          32'((last_valid_cyc - c0 >= (FRAME_BITS * CPB - CPB / 2 - 12)) &&
              (last_valid_cyc - c0 <= (FRAME_BITS * CPB - CPB / 2 + 20))), 1);
    drive_bit(1'b1, 50);

    // Reset mid-frame returns the data register to zero with no pulse
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, CPB);
    uart_rxd = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_data = 8'h00;
    check("midframe_reset_data", uart_rx_data, 0);
    drive_bit(1'b1, CPB);

    // Back-to-back 0x00 then 0xFF
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    drive_bit(1'b1, 30);

    // 100-cycle glitch is rejected and the next frame still lands
    drive_bit(1'b0, 100);
    drive_bit(1'b1, 140);
    check("glitch_no_pulse", exp_q.size(), 0);
    send_frame(8'h96, 1'b1, 1'b0);
    drive_bit(1'b1, 30);

    // Line held low for 12 bit times gives exactly one break
    begin
      ev_t e;
      e.kind = EV_BREAK;
      e.data = 8'h00;
      exp_q.push_back(e);
    end
    drive_bit(1'b0, 12 * CPB);
    check("break_seen", exp_q.size(), 0);
    drive_bit(1'b1, 2 * CPB);
    send_frame(8'h81, 1'b1, 1'b0);
    drive_bit(1'b1, 30);

    // Framing error with non-zero data is dropped
    send_frame(8'h3C, 1'b0, 1'b0);
    drive_bit(1'b1, CPB);
    check("framing_data_kept", uart_rx_data, model_data);

    // Receiver disabled during bit 4 discards the frame
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(i[0], CPB);
    drive_bit(1'b1, CPB / 2);
    uart_rx_en = 1'b0;
    drive_bit(1'b1, CPB / 2);
    for (int i = 5; i < FRAME_BITS - 1; i++) drive_bit(i[0], CPB);
    drive_bit(1'b1, CPB);
    uart_rx_en = 1'b1;
    drive_bit(1'b1, 20);
    check("abort_data_kept", uart_rx_data, model_data);
    send_frame(8'hC3, 1'b1, 1'b0);
    drive_bit(1'b1, 20);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h5A, 1'b1, 1'b0);
    drive_bit(1'b1, 20);
    send_frame(8'h5A, 1'b1, 1'b1);
    drive_bit(1'b1, 20);
    check("perr_data_kept", uart_rx_data, model_data);
`endif

    // Randomized frames
    for (int n = 0; n < 5; n++) begin
      d = 8'($urandom);
      k = $urandom_range(0, 9);
      if (k == 0) begin
        send_frame(8'h00, 1'b0, 1'b0);
        drive_bit(1'b1, CPB);
      end else if (k == 1) begin
        if (d == 8'h00) d = 8'h01;
        send_frame(d, 1'b0, 1'b0);
        drive_bit(1'b1, CPB);
`ifdef UART_RX_PARITY_EN
      end else if (k == 2) begin
        send_frame(d, 1'b1, 1'b1);
        drive_bit(1'b1, $urandom_range(0, 40));
`endif
      end else begin
        send_frame(d, 1'b1, 1'b0);
        drive_bit(1'b1, $urandom_range(0, 40));
      end
      check("random_data_track", uart_rx_data, model_data);
    end

    drive_bit(1'b1, 2 * CPB);
    check("queue_empty_end", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
